// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - two-requester arbiter sharing one SRAM controller port
// Optional ack watchdog enabled by defining SRAM_ARB_TIMEOUT_EN.
module sram_port_arbiter #(
    parameter int AHB_DWIDTH     = 32,
    parameter int ADDR_WIDTH     = 20,
    parameter int FIXED_PRIO     = 0,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  HCLK,
    input  logic                  HRESETN,
    input  logic                  rqa_req,
    input  logic                  rqa_write,
    input  logic [2:0]            rqa_size,
    input  logic [ADDR_WIDTH-1:0] rqa_addr,
    input  logic [AHB_DWIDTH-1:0] rqa_wdata,
    output logic                  rqa_done,
    output logic [AHB_DWIDTH-1:0] rqa_rdata,
    output logic                  rqa_err,
    input  logic                  rqb_req,
    input  logic                  rqb_write,
    input  logic [2:0]            rqb_size,
    input  logic [ADDR_WIDTH-1:0] rqb_addr,
    input  logic [AHB_DWIDTH-1:0] rqb_wdata,
    output logic                  rqb_done,
    output logic [AHB_DWIDTH-1:0] rqb_rdata,
    output logic                  rqb_err,
    output logic                  sram_req,
    output logic                  sram_write,
    output logic [2:0]            sram_size,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [AHB_DWIDTH-1:0] sram_wdata,
    input  logic                  sram_ack,
    input  logic [AHB_DWIDTH-1:0] sram_rdata,
    input  logic                  sram_busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_ACK, S_DONE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_gnt_b;
    logic                  r_last_b;
    logic [AHB_DWIDTH-1:0] r_rdata_a;
    logic [AHB_DWIDTH-1:0] r_rdata_b;
    logic                  w_grant;
    logic                  w_pick_b;
    logic                  w_timeout;
    logic                  w_err;
    logic                  w_done;
    logic [AHB_DWIDTH-1:0] w_rdata_now;

`ifdef SRAM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    // An ack arriving on the limit cycle still wins over the watchdog.
    assign w_timeout = (r_state == S_WAIT_ACK) && !sram_ack &&
                       (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_err     = r_err;

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_cnt <= (r_state == S_WAIT_ACK) ? r_cnt + 1'b1 : '0;
            if (r_state == S_WAIT_ACK)
                r_err <= w_timeout;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign w_err     = 1'b0;
`endif

    always_comb begin
        w_pick_b = rqb_req;
        if (rqa_req && rqb_req)
            w_pick_b = (FIXED_PRIO != 0) ? 1'b0 : !r_last_b;
    end

    always_comb begin
        w_next  = r_state;
        w_grant = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!sram_busy && (rqa_req || rqb_req)) begin
                    w_grant = 1'b1;
                    w_next  = S_ISSUE;
                end
            end
            S_ISSUE:    w_next = S_WAIT_ACK;
            S_WAIT_ACK: if (sram_ack || w_timeout) w_next = S_DONE;
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETN) begin
        if (!HRESETN) begin
            r_state    <= S_IDLE;
            r_gnt_b    <= 1'b0;
            r_last_b   <= 1'b1;
            sram_write <= 1'b0;
            sram_size  <= '0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            r_rdata_a  <= '0;
            r_rdata_b  <= '0;
        end else begin
            r_state <= w_next;
            if (w_grant) begin
                r_gnt_b    <= w_pick_b;
                r_last_b   <= w_pick_b;
                sram_write <= w_pick_b ? rqb_write : rqa_write;
                sram_size  <= w_pick_b ? rqb_size  : rqa_size;
                sram_addr  <= w_pick_b ? rqb_addr  : rqa_addr;
                sram_wdata <= w_pick_b ? rqb_wdata : rqa_wdata;
            end
            if (rqa_done) r_rdata_a <= w_rdata_now;
            if (rqb_done) r_rdata_b <= w_rdata_now;
        end
    end

    // Controller rdata is only valid in the DONE cycle, so it is passed through then and held afterwards.
    assign w_done      = (r_state == S_DONE);
    assign w_rdata_now = w_err ? '0 : sram_rdata;
    assign sram_req    = (r_state == S_ISSUE);
    assign rqa_done    = w_done && !r_gnt_b;
    assign rqb_done    = w_done && r_gnt_b;
    assign rqa_err     = rqa_done && w_err;
    assign rqb_err     = rqb_done && w_err;
    assign rqa_rdata   = rqa_done ? w_rdata_now : r_rdata_a;
    assign rqb_rdata   = rqb_done ? w_rdata_now : r_rdata_b;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - self-checking bench for sram_port_arbiter
module tb_sram_port_arbiter;

    typedef struct {
        logic        port;
        logic [31:0] rdata;
        logic        err;
        logic        chk;
    } exp_t;

    logic        HCLK = 1'b0;
    logic        HRESETN = 1'b0;
    logic        rqa_req = 0, rqa_write = 0, rqb_req = 0, rqb_write = 0;
    logic [2:0]  rqa_size = 0, rqb_size = 0;
    logic [19:0] rqa_addr = 0, rqb_addr = 0;
    logic [31:0] rqa_wdata = 0, rqb_wdata = 0;
    logic        sram_busy = 0;
    logic        ack_en = 1, ack_force = 0;

    logic        rqa_done_r, rqb_done_r, rqa_err_r, rqb_err_r, sram_req_r, sram_write_r;
    logic [31:0] rqa_rdata_r, rqb_rdata_r, sram_wdata_r, sram_rdata_r;
    logic [2:0]  sram_size_r;
    logic [19:0] sram_addr_r;
    logic        sram_ack_r, r_ack_r;

    logic        rqa_done_f, rqb_done_f, rqa_err_f, rqb_err_f, sram_req_f, sram_write_f;
    logic [31:0] rqa_rdata_f, rqb_rdata_f, sram_wdata_f, sram_rdata_f;
    logic [2:0]  sram_size_f;
    logic [19:0] sram_addr_f;
    logic        sram_ack_f, r_ack_f;

    int   checks = 0;
    int   errors = 0;
    exp_t q_r[$];
    exp_t q_f[$];

    always #5 HCLK = ~HCLK;

    sram_port_arbiter #(.AHB_DWIDTH(32), .ADDR_WIDTH(20), .FIXED_PRIO(0), .TIMEOUT_CYCLES(16)) u_rr (
        .HCLK(HCLK), .HRESETN(HRESETN),
        .rqa_req(rqa_req), .rqa_write(rqa_write), .rqa_size(rqa_size), .rqa_addr(rqa_addr),
        .rqa_wdata(rqa_wdata), .rqa_done(rqa_done_r), .rqa_rdata(rqa_rdata_r), .rqa_err(rqa_err_r),
        .rqb_req(rqb_req), .rqb_write(rqb_write), .rqb_size(rqb_size), .rqb_addr(rqb_addr),
        .rqb_wdata(rqb_wdata), .rqb_done(rqb_done_r), .rqb_rdata(rqb_rdata_r), .rqb_err(rqb_err_r),
        .sram_req(sram_req_r), .sram_write(sram_write_r), .sram_size(sram_size_r),
        .sram_addr(sram_addr_r), .sram_wdata(sram_wdata_r), .sram_ack(sram_ack_r),
        .sram_rdata(sram_rdata_r), .sram_busy(sram_busy));

    sram_port_arbiter #(.AHB_DWIDTH(32), .ADDR_WIDTH(20), .FIXED_PRIO(1), .TIMEOUT_CYCLES(16)) u_fx (
        .HCLK(HCLK), .HRESETN(HRESETN),
        .rqa_req(rqa_req), .rqa_write(rqa_write), .rqa_size(rqa_size), .rqa_addr(rqa_addr),
        .rqa_wdata(rqa_wdata), .rqa_done(rqa_done_f), .rqa_rdata(rqa_rdata_f), .rqa_err(rqa_err_f),
        .rqb_req(rqb_req), .rqb_write(rqb_write), .rqb_size(rqb_size), .rqb_addr(rqb_addr),
        .rqb_wdata(rqb_wdata), .rqb_done(rqb_done_f), .rqb_rdata(rqb_rdata_f), .rqb_err(rqb_err_f),
        .sram_req(sram_req_f), .sram_write(sram_write_f), .sram_size(sram_size_f),
        .sram_addr(sram_addr_f), .sram_wdata(sram_wdata_f), .sram_ack(sram_ack_f),
        .sram_rdata(sram_rdata_f), .sram_busy(sram_busy));

    function automatic logic [31:0] f_rd(input logic [19:0] a);
        return (a == 20'h00010) ? 32'hDEADBEEF : {12'hC0D, a};
    endfunction

    // Nominal controller: ack the cycle after sram_req, rdata the cycle after ack.
    assign sram_ack_r = r_ack_r | ack_force;
    assign sram_ack_f = r_ack_f | ack_force;
    always @(posedge HCLK) begin
        r_ack_r      <= ack_en & sram_req_r;
        r_ack_f      <= ack_en & sram_req_f;
        sram_rdata_r <= sram_ack_r ? f_rd(sram_addr_r) : 32'h0BAD0BAD;
        sram_rdata_f <= sram_ack_f ? f_rd(sram_addr_f) : 32'h0BAD0BAD;
    end

    always @(negedge HCLK) begin
        exp_t e;
        if (HRESETN && (rqa_done_r || rqb_done_r)) begin
            checks++;
            if (q_r.size() == 0) begin
                errors++;
                $display("FAIL sb_rr: unexpected done a=%0b b=%0b", rqa_done_r, rqb_done_r);
            end else begin
                e = q_r.pop_front();
                if (rqa_done_r === rqb_done_r || rqb_done_r !== e.port
                    || (rqb_done_r ? rqb_err_r : rqa_err_r) !== e.err
                    || (e.chk && (rqb_done_r ? rqb_rdata_r : rqa_rdata_r) !== e.rdata)) begin
                    errors++;
                    $display("FAIL sb_rr: got a=%0b b=%0b rd=%h/%h err=%0b/%0b, want port=%0b rd=%h err=%0b",
                             rqa_done_r, rqb_done_r, rqa_rdata_r, rqb_rdata_r, rqa_err_r, rqb_err_r,
                             e.port, e.rdata, e.err);
                end
            end
        end
        if (HRESETN && (rqa_done_f || rqb_done_f)) begin
            checks++;
            if (q_f.size() == 0) begin
                errors++;
                $display("FAIL sb_fx: unexpected done a=%0b b=%0b", rqa_done_f, rqb_done_f);
            end else begin
                e = q_f.pop_front();
                if (rqa_done_f === rqb_done_f || rqb_done_f !== e.port
                    || (rqb_done_f ? rqb_err_f : rqa_err_f) !== e.err
                    || (e.chk && (rqb_done_f ? rqb_rdata_f : rqa_rdata_f) !== e.rdata)) begin
                    errors++;
                    $display("FAIL sb_fx: got a=%0b b=%0b rd=%h/%h err=%0b/%0b, want port=%0b rd=%h err=%0b",
                             rqa_done_f, rqb_done_f, rqa_rdata_f, rqb_rdata_f, rqa_err_f, rqb_err_f,
                             e.port, e.rdata, e.err);
                end
            end
        end
    end

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic apply_reset();
        HRESETN = 1'b0;
        rqa_req = 0; rqb_req = 0; sram_busy = 0; ack_en = 1; ack_force = 0;
        step(); step();
        HRESETN = 1'b1;
    endtask

    task automatic test_reset();
        HRESETN = 1'b0;
        step(); step();
        @(negedge HCLK);
        checks++;
        if ({sram_req_r, sram_write_r, sram_size_r, sram_addr_r, sram_wdata_r, rqa_done_r, rqb_done_r,
             rqa_err_r, rqb_err_r, rqa_rdata_r, rqb_rdata_r} !== '0
            || {sram_req_f, sram_size_f, sram_addr_f, sram_wdata_f, rqa_rdata_f, rqb_rdata_f} !== '0) begin
            errors++;
            $display("FAIL reset_values: addr=%h size=%b req=%b rd=%h/%h, want all zero",
                     sram_addr_r, sram_size_r, sram_req_r, rqa_rdata_r, rqb_rdata_r);
        end
        step();
        HRESETN = 1'b1;
        step();
    endtask

    task automatic test_single_read();
        rqa_addr = 20'h00010; rqa_size = 3'b010; rqa_write = 0; rqa_req = 1;
        q_r.push_back('{1'b0, 32'hDEADBEEF, 1'b0, 1'b1});
        q_f.push_back('{1'b0, 32'hDEADBEEF, 1'b0, 1'b1});
        for (int i = 0; i < 5; i++) begin
            @(negedge HCLK);
            checks++;
            if (sram_req_r !== (i == 1) || rqa_done_r !== (i == 3) || rqb_done_r !== 1'b0) begin
                errors++;
                $display("FAIL single_timing[%0d]: req=%b done_a=%b done_b=%b, want req=%b done_a=%b done_b=0",
                         i, sram_req_r, rqa_done_r, rqb_done_r, i == 1, i == 3);
            end
            step();
            if (i == 3) rqa_req = 0;
        end
        @(negedge HCLK);
        checks++;
        if (rqa_rdata_r !== 32'hDEADBEEF || rqb_rdata_r !== 32'h0) begin
            errors++;
            $display("FAIL single_hold: rdata_a=%h rdata_b=%h, want deadbeef 0", rqa_rdata_r, rqb_rdata_r);
        end
        step();
    endtask

    task automatic test_back_to_back();
        apply_reset();
        rqa_addr = 20'h00100; rqb_addr = 20'h00200; rqa_write = 0; rqb_write = 0;
        for (int k = 0; k < 4; k++) begin
            q_r.push_back('{k[0], f_rd(k[0] ? 20'h00200 : 20'h00100), 1'b0, 1'b1});
            q_f.push_back('{1'b0, f_rd(20'h00100), 1'b0, 1'b1});
        end
        rqa_req = 1; rqb_req = 1;
        for (int i = 0; i < 16; i++) begin
            @(negedge HCLK);
            checks++;
            if ((rqa_done_r | rqb_done_r) !== (i % 4 == 3) || (rqa_done_f | rqb_done_f) !== (i % 4 == 3)
                || sram_req_r !== (i % 4 == 1) || sram_req_f !== (i % 4 == 1)) begin
                errors++;
                $display("FAIL b2b_timing[%0d]: done_rr=%b done_fx=%b req=%b/%b, want done=%b req=%b",
                         i, rqa_done_r | rqb_done_r, rqa_done_f | rqb_done_f, sram_req_r, sram_req_f,
                         i % 4 == 3, i % 4 == 1);
            end
            step();
        end
        rqa_req = 0; rqb_req = 0;
        step();
    endtask

    task automatic test_busy();
        apply_reset();
        rqa_addr = 20'h00555; rqa_size = 3'b000; rqa_wdata = 32'hAAAAAAAA;
        rqb_addr = 20'h00020; rqb_size = 3'b001; rqb_wdata = 32'h12345678; rqb_write = 1;
        sram_busy = 1; rqb_req = 1;
        q_r.push_back('{1'b1, 32'h0, 1'b0, 1'b0});
        q_f.push_back('{1'b1, 32'h0, 1'b0, 1'b0});
        for (int i = 0; i < 5; i++) begin
            @(negedge HCLK);
            checks++;
            if (sram_req_r !== 1'b0 || sram_req_f !== 1'b0) begin
                errors++;
                $display("FAIL busy_block[%0d]: sram_req=%b/%b, want 0", i, sram_req_r, sram_req_f);
            end
            step();
        end
        sram_busy = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge HCLK);
            checks++;
            if (sram_req_r !== (i == 1) || rqb_done_r !== (i == 3)) begin
                errors++;
                $display("FAIL busy_release[%0d]: req=%b done_b=%b, want req=%b done_b=%b",
                         i, sram_req_r, rqb_done_r, i == 1, i == 3);
            end
            if (i >= 1) begin
                checks++;
                if (sram_addr_r !== 20'h00020 || sram_size_r !== 3'b001 || sram_wdata_r !== 32'h12345678
                    || sram_write_r !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_attr[%0d]: addr=%h size=%b wdata=%h wr=%b, want 00020 001 12345678 1",
                             i, sram_addr_r, sram_size_r, sram_wdata_r, sram_write_r);
                end
            end
            step();
        end
        rqb_req = 0; rqb_write = 0;
        step();
    endtask

    task automatic test_reset_mid();
        ack_en = 0;
        rqa_addr = 20'h00030; rqa_size = 3'b010; rqa_req = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            if (i < 2) step();
        end
        HRESETN = 1'b0;
        #1;
        checks++;
        if (sram_addr_r !== 20'h0 || sram_size_r !== 3'b0 || sram_req_r !== 1'b0 || rqb_rdata_r !== 32'h0
            || rqa_done_r !== 1'b0 || sram_addr_f !== 20'h0) begin
            errors++;
            $display("FAIL reset_mid: addr=%h size=%b req=%b rdata_b=%h, want all zero",
                     sram_addr_r, sram_size_r, sram_req_r, rqb_rdata_r);
        end
        rqa_req = 0;
        step();
        HRESETN = 1'b1;
        ack_en = 1;
        ack_force = 1;
        step();
        ack_force = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge HCLK);
            checks++;
            if ({sram_req_r, rqa_done_r, rqb_done_r, sram_req_f, rqa_done_f, rqb_done_f} !== 6'b0) begin
                errors++;
                $display("FAIL reset_late_ack[%0d]: req=%b done=%b%b, want 0", i, sram_req_r, rqa_done_r, rqb_done_r);
            end
            step();
        end
    endtask

    task automatic test_ack_watchdog();
        apply_reset();
        ack_en = 0;
        rqa_addr = 20'h00040; rqa_size = 3'b010; rqa_write = 0; rqa_req = 1;
`ifdef SRAM_ARB_TIMEOUT_EN
        q_r.push_back('{1'b0, 32'h0, 1'b1, 1'b1});
        q_f.push_back('{1'b0, 32'h0, 1'b1, 1'b1});
        for (int i = 0; i < 20; i++) begin
            @(negedge HCLK);
            checks++;
            if (rqa_done_r !== (i == 18) || rqa_err_r !== (i == 18) || sram_req_r !== (i == 1)) begin
                errors++;
                $display("FAIL timeout[%0d]: done=%b err=%b req=%b, want done=%b err=%b",
                         i, rqa_done_r, rqa_err_r, sram_req_r, i == 18, i == 18);
            end
            step();
            if (i == 18) rqa_req = 0;
        end
`else
        q_r.push_back('{1'b0, f_rd(20'h00040), 1'b0, 1'b1});
        q_f.push_back('{1'b0, f_rd(20'h00040), 1'b0, 1'b1});
        for (int i = 0; i < 30; i++) begin
            @(negedge HCLK);
            checks++;
            if (rqa_done_r !== 1'b0 || rqa_err_r !== 1'b0) begin
                errors++;
                $display("FAIL no_timeout[%0d]: done=%b err=%b, want 0 0", i, rqa_done_r, rqa_err_r);
            end
            step();
        end
        ack_force = 1;
        step();
        ack_force = 0;
        @(negedge HCLK);
        checks++;
        if (rqa_done_r !== 1'b1 || rqa_err_r !== 1'b0) begin
            errors++;
            $display("FAIL slow_ack: done=%b err=%b, want 1 0", rqa_done_r, rqa_err_r);
        end
        step();
        rqa_req = 0;
`endif
        ack_en = 1;
        step();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_busy();
        test_reset_mid();
        test_ack_watchdog();
        step(); step();
        checks++;
        if (q_r.size() != 0 || q_f.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: pending rr=%0d fx=%0d, want 0 0", q_r.size(), q_f.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
